alu_arbiter: RTL and testbench

- Shares the single combinational 4-bit ALU (add/sub/mul/div/AND/OR/XOR/NOT, 8-bit result) between two requesters, e.g. the switch/button front end and a serial command port.
- Arbitrates round-robin and latches the winner's operands onto the ALU inputs.
- Waits a configurable settle time, captures the result, and returns it over a per-requester valid/ready handshake.
- Sits between the requesters and the ALU; the display path consumes the captured result.

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one combinational 4-bit ALU between
//            two requesters, with settle timing and valid/ready responses.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic [2:0] req_op0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  input  logic [2:0] req_op1,
  output logic [1:0] req_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0]       C_OP_DIV   = 3'b011;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(ALU_LATENCY - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [2:0]       r_alu_op;
  logic [7:0]       r_rsp_result;
  logic             r_rsp_err;
  logic [1:0]       r_rsp_valid;
  logic             r_busy;

  logic             w_grant;
  logic [1:0]       w_ready;
  logic             w_accept;
  logic [3:0]       w_sel_a;
  logic [3:0]       w_sel_b;
  logic [2:0]       w_sel_op;
  logic             w_div_zero;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req_valid[1];
    end
  end

  always_comb begin
    w_ready = 2'b00;
    if ((r_state == S_IDLE) && (req_valid != 2'b00)) begin
      w_ready = w_grant ? 2'b10 : 2'b01;
    end
  end

  assign w_accept   = (w_ready != 2'b00);
  assign w_sel_a    = w_grant ? req_a1  : req_a0;
  assign w_sel_b    = w_grant ? req_b1  : req_b0;
  assign w_sel_op   = w_grant ? req_op1 : req_op0;
  assign w_div_zero = (w_sel_op == C_OP_DIV) && (w_sel_b == 4'd0);

  // The reset gate sits only on the port so the flops never see reset as data.
  assign req_ready  = reset ? w_ready : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_op     <= 3'd0;
      r_rsp_result <= 8'd0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            r_grant  <= w_grant;
            r_busy   <= 1'b1;
            if (w_div_zero) begin
              // Division by zero is answered directly without waiting on the ALU.
              r_rsp_result <= 8'd0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= w_grant ? 2'b10 : 2'b01;
              r_state      <= S_RESP;
            end else begin
              r_rsp_err <= 1'b0;
              r_cnt     <= C_CNT_INIT;
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_result <= alu_result;
            r_rsp_valid  <= r_grant ? 2'b10 : 2'b01;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_grant]) begin
            r_last_grant <= r_grant;
            r_rsp_valid  <= 2'b00;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter (latency 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  int         checks;
  int         failures;

  // Latency-1 instance
  logic [1:0] req_valid, rsp_ready, req_ready, rsp_valid;
  logic [3:0] req_a0, req_b0, req_a1, req_b1, alu_a, alu_b;
  logic [2:0] req_op0, req_op1, alu_op;
  logic [7:0] alu_result, rsp_result;
  logic       rsp_err, busy;

  // Latency-4 instance
  logic [1:0] req_valid_l4, rsp_ready_l4, req_ready_l4, rsp_valid_l4;
  logic [3:0] req_a0_l4, req_b0_l4, req_a1_l4, req_b1_l4, alu_a_l4, alu_b_l4;
  logic [2:0] req_op0_l4, req_op1_l4, alu_op_l4;
  logic [7:0] alu_result_l4, rsp_result_l4;
  logic       rsp_err_l4, busy_l4;

  // External ALU; divide-by-zero yields 0xFF so a wrongly captured result shows.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [7:0] ea, eb;
    ea = {4'd0, a};
    eb = {4'd0, b};
    case (op)
      3'b000:  return ea + eb;
      3'b001:  return ea - eb;
      3'b010:  return ea * eb;
      3'b011:  return (b == 4'd0) ? 8'hFF : ea / eb;
      3'b100:  return ea & eb;
      3'b101:  return ea | eb;
      3'b110:  return ea ^ eb;
      default: return {4'd0, ~a};
    endcase
  endfunction

  assign alu_result    = alu_model(alu_a, alu_b, alu_op);
  assign alu_result_l4 = alu_model(alu_a_l4, alu_b_l4, alu_op_l4);

  alu_arbiter #(.ALU_LATENCY(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  alu_arbiter #(.ALU_LATENCY(4), .CNT_W(4)) u_dut_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid_l4),
    .req_a0(req_a0_l4), .req_b0(req_b0_l4), .req_op0(req_op0_l4),
    .req_a1(req_a1_l4), .req_b1(req_b1_l4), .req_op1(req_op1_l4),
    .req_ready(req_ready_l4), .alu_a(alu_a_l4), .alu_b(alu_b_l4), .alu_op(alu_op_l4),
    .alu_result(alu_result_l4), .rsp_valid(rsp_valid_l4), .rsp_ready(rsp_ready_l4),
    .rsp_result(rsp_result_l4), .rsp_err(rsp_err_l4), .busy(busy_l4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts falling edges until a response appears; -1 if none within 50.
  task automatic wait_rsp(input bit l4, output int n);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    while (!got && k < 50) begin
      @(negedge clk);
      k++;
      got = l4 ? (rsp_valid_l4 != 2'b00) : (rsp_valid != 2'b00);
    end
    n = got ? k : -1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_valid_l4 = 2'b11;
    #1 reset = 1'b0;
    #2;
    checks++;
    if (req_ready !== 2'b00 || req_ready_l4 !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b/%b expected 00/00", req_ready, req_ready_l4);
    end
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 8'h00) begin
      failures++;
      $display("FAIL reset_rsp: got valid=%b busy=%b err=%b res=%h expected 00 0 0 00",
               rsp_valid, busy, rsp_err, rsp_result);
    end
    checks++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'b000) begin
      failures++;
      $display("FAIL reset_alu: got a=%h b=%h op=%b expected 0 0 000", alu_a, alu_b, alu_op);
    end
    req_valid = 2'b00;
    req_valid_l4 = 2'b00;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int n;
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 4'd7; req_b0 = 4'd9; req_op0 = 3'b000; rsp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got ready=%b busy=%b expected 01 0", req_ready, busy);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL single_latency: got %0d expected 2", n);
    end
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 8'h10 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got valid=%b res=%h err=%b expected 01 10 0",
               rsp_valid, rsp_result, rsp_err);
    end
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 8'h10) begin
      failures++;
      $display("FAIL single_idle: got valid=%b busy=%b res=%h expected 00 0 10",
               rsp_valid, busy, rsp_result);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    int n;
    reset_dut();
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a0 = 4'd15; req_b0 = 4'd15; req_op0 = 3'b010;
    req_a1 = 4'd3;  req_b1 = 4'd5;  req_op1 = 3'b001;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rr_first_grant: got %b expected 01", req_ready);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2 || rsp_valid !== 2'b01 || rsp_result !== 8'hE1) begin
      failures++;
      $display("FAIL rr_rsp0: got n=%0d valid=%b res=%h expected 2 01 e1", n, rsp_valid, rsp_result);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL rr_second_grant: got ready=%b valid=%b expected 10 00", req_ready, rsp_valid);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2 || rsp_valid !== 2'b10 || rsp_result !== 8'hFE || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rr_rsp1: got n=%0d valid=%b res=%h err=%b expected 2 10 fe 0",
               n, rsp_valid, rsp_result, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rr_third_grant: got %b expected 01", req_ready);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2 || rsp_valid !== 2'b01 || rsp_result !== 8'hE1) begin
      failures++;
      $display("FAIL rr_rsp2: got n=%0d valid=%b res=%h expected 2 01 e1", n, rsp_valid, rsp_result);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_div_zero();
    int n;
    @(negedge clk);
    req_valid = 2'b10; req_a1 = 4'd9; req_b1 = 4'd0; req_op1 = 3'b011; rsp_ready = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL div0_ready: got %b expected 10", req_ready);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 1 || rsp_valid !== 2'b10 || rsp_result !== 8'h00 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL div0_rsp: got n=%0d valid=%b res=%h err=%b expected 1 10 00 1",
               n, rsp_valid, rsp_result, rsp_err);
    end
    req_b1 = 4'd3;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL div_ready: got ready=%b valid=%b expected 10 00", req_ready, rsp_valid);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2 || rsp_valid !== 2'b10 || rsp_result !== 8'h03 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL div_rsp: got n=%0d valid=%b res=%h err=%b expected 2 10 03 0",
               n, rsp_valid, rsp_result, rsp_err);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 4'd2; req_b0 = 4'd3; req_op0 = 3'b100; rsp_ready = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL stall_ready: got %b expected 01", req_ready);
    end
    wait_rsp(1'b0, n);
    checks++;
    if (n !== 2 || rsp_valid !== 2'b01 || rsp_result !== 8'h02) begin
      failures++;
      $display("FAIL stall_rsp: got n=%0d valid=%b res=%h expected 2 01 02", n, rsp_valid, rsp_result);
    end
    req_a0 = 4'd15;
    for (int i = 0; i < 20; i++) begin
      rsp_ready = (i >= 10) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 8'h02 || req_ready !== 2'b00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b res=%h ready=%b busy=%b expected 01 02 00 1",
                 i, rsp_valid, rsp_result, req_ready, busy);
      end
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b01) begin
      failures++;
      $display("FAIL stall_release: got valid=%b busy=%b ready=%b expected 00 0 01",
               rsp_valid, busy, req_ready);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_latency4();
    @(negedge clk);
    req_valid_l4 = 2'b01; req_a0_l4 = 4'h5; req_b0_l4 = 4'h0; req_op0_l4 = 3'b111;
    rsp_ready_l4 = 2'b01;
    #1;
    checks++;
    if (req_ready_l4 !== 2'b01) begin
      failures++;
      $display("FAIL lat4_ready: got %b expected 01", req_ready_l4);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid_l4 = 2'b00;
        req_a0_l4 = 4'hC;
      end
      checks++;
      if (rsp_valid_l4 !== 2'b00 || alu_a_l4 !== 4'h5 || alu_op_l4 !== 3'b111 ||
          busy_l4 !== 1'b1 || req_ready_l4 !== 2'b00) begin
        failures++;
        $display("FAIL lat4_wait[%0d]: got valid=%b a=%h op=%b busy=%b ready=%b expected 00 5 111 1 00",
                 i, rsp_valid_l4, alu_a_l4, alu_op_l4, busy_l4, req_ready_l4);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_l4 !== 2'b01 || rsp_result_l4 !== 8'h0A || rsp_err_l4 !== 1'b0) begin
      failures++;
      $display("FAIL lat4_rsp: got valid=%b res=%h err=%b expected 01 0a 0",
               rsp_valid_l4, rsp_result_l4, rsp_err_l4);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_l4 !== 2'b00 || busy_l4 !== 1'b0) begin
      failures++;
      $display("FAIL lat4_done: got valid=%b busy=%b expected 00 0", rsp_valid_l4, busy_l4);
    end
    rsp_ready_l4 = 2'b00;
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  bad;
    @(negedge clk);
    req_valid_l4 = 2'b11;
    req_a0_l4 = 4'd1; req_b0_l4 = 4'd1; req_op0_l4 = 3'b000;
    req_a1_l4 = 4'd6; req_b1_l4 = 4'd2; req_op1_l4 = 3'b000;
    #1;
    checks++;
    if (req_ready_l4 !== 2'b10) begin
      failures++;
      $display("FAIL mid_grant: got %b expected 10", req_ready_l4);
    end
    @(negedge clk);
    checks++;
    if (busy_l4 !== 1'b1 || alu_a_l4 !== 4'd6) begin
      failures++;
      $display("FAIL mid_wait: got busy=%b a=%h expected 1 6", busy_l4, alu_a_l4);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy_l4 !== 1'b0 || rsp_valid_l4 !== 2'b00 || req_ready_l4 !== 2'b00 ||
        alu_a_l4 !== 4'd0 || alu_b_l4 !== 4'd0 || alu_op_l4 !== 3'b000) begin
      failures++;
      $display("FAIL mid_async: got busy=%b valid=%b ready=%b a=%h b=%h op=%b expected 0 00 00 0 0 000",
               busy_l4, rsp_valid_l4, req_ready_l4, alu_a_l4, alu_b_l4, alu_op_l4);
    end
    checks++;
    if (rsp_result_l4 !== 8'h00 || rsp_err_l4 !== 1'b0 || rsp_result !== 8'h00) begin
      failures++;
      $display("FAIL mid_result_clear: got %h/%b/%h expected 00/0/00",
               rsp_result_l4, rsp_err_l4, rsp_result);
    end
    req_valid_l4 = 2'b00;
    rsp_ready_l4 = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_l4 !== 2'b00 || busy_l4 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_no_rsp: got valid=%b busy=%b expected 00 0", rsp_valid_l4, busy_l4);
    end
    req_valid_l4 = 2'b11;
    #1;
    checks++;
    if (req_ready_l4 !== 2'b01) begin
      failures++;
      $display("FAIL mid_tie_after_reset: got %b expected 01", req_ready_l4);
    end
    wait_rsp(1'b1, n);
    checks++;
    if (n !== 5 || rsp_valid_l4 !== 2'b01 || rsp_result_l4 !== 8'h02) begin
      failures++;
      $display("FAIL mid_rsp_after_reset: got n=%0d valid=%b res=%h expected 5 01 02",
               n, rsp_valid_l4, rsp_result_l4);
    end
    req_valid_l4 = 2'b00;
    @(negedge clk);
    rsp_ready_l4 = 2'b00;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 4'd0; req_b0 = 4'd0; req_op0 = 3'd0;
    req_a1 = 4'd0; req_b1 = 4'd0; req_op1 = 3'd0;
    req_valid_l4 = 2'b00; rsp_ready_l4 = 2'b00;
    req_a0_l4 = 4'd0; req_b0_l4 = 4'd0; req_op0_l4 = 3'd0;
    req_a1_l4 = 4'd0; req_b1_l4 = 4'd0; req_op1_l4 = 3'd0;

    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_latency4();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
